// File: rtl/butterfly_datapath.sv
// Radix-2 butterfly datapath: Y = A + W*B, Z = A - W*B in signed fixed point,
// driven one register update per strobe from the sequencing FSM.
module butterfly_datapath #(
  parameter int DATA_W = 8
) (
  input  logic                  Clock,
  input  logic                  nReset,
  input  logic [2*DATA_W-1:0]   DataIn,
  input  logic                  clear,
  input  logic                  store_W,
  input  logic                  store_B,
  input  logic                  store_A,
  input  logic                  calc_ReWB,
  input  logic                  calc_ImY,
  input  logic                  calc_ImZ,
  input  logic                  calc_ReZ2,
  input  logic                  calc_ReZ,
  input  logic                  calc_ReY,
  input  logic                  display_ReY,
  input  logic                  display_ImY,
  input  logic                  display_ReZ,
  input  logic                  display_ImZ,
  output logic [DATA_W-1:0]     DispOut,
  output logic                  DispValid,
  output logic                  Overflow
);

  localparam int PW = 2*DATA_W + 2;
  localparam int IW = DATA_W + 1;
  localparam int SW = DATA_W + 2;
  localparam logic signed [PW-1:0] RND = PW'(2 ** (DATA_W-2));
  localparam logic signed [SW-1:0] MAXV = SW'(2 ** (DATA_W-1) - 1);
  localparam logic signed [SW-1:0] MINV = SW'(-(2 ** (DATA_W-1)));

  logic signed [DATA_W-1:0] inRe, inIm;
  logic signed [DATA_W-1:0] reW, imW, reB, imB, reA, imA;
  logic signed [DATA_W-1:0] reY, imY, reZ, imZ;
  logic signed [IW-1:0]     reWB, imWB;
  logic                     imzArmed;

  logic signed [PW-1:0]     reProd, imProd;
  logic signed [IW-1:0]     reWBNext, imWBNext;
  logic signed [SW-1:0]     reYSum, reZSum, imYSum, imZSum;

  function automatic logic clamps(input logic signed [SW-1:0] v);
    return (v > MAXV) || (v < MINV);
  endfunction

  function automatic logic signed [DATA_W-1:0] sat(
    input logic signed [SW-1:0] v
  );
    if (v > MAXV) return DATA_W'(MAXV);
    if (v < MINV) return DATA_W'(MINV);
    return DATA_W'(v);
  endfunction

  assign inRe = DataIn[2*DATA_W-1:DATA_W];
  assign inIm = DataIn[DATA_W-1:0];

  // Extra product headroom keeps the rounded sum exact before truncation to IW
  assign reProd = PW'(reW) * PW'(reB) - PW'(imW) * PW'(imB) + RND;
  assign imProd = PW'(reW) * PW'(imB) + PW'(imW) * PW'(reB) + RND;
  assign reWBNext = IW'(reProd >>> (DATA_W-1));
  assign imWBNext = IW'(imProd >>> (DATA_W-1));

  assign reYSum = SW'(reA) + SW'(reWB);
  assign reZSum = SW'(reA) - SW'(reWB);
  assign imYSum = SW'(imA) + SW'(imWB);
  assign imZSum = imzArmed ? SW'(imA) - SW'(imWB) : SW'(imA);

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      reW <= '0; imW <= '0;
      reB <= '0; imB <= '0;
      reA <= '0; imA <= '0;
      reWB <= '0; imWB <= '0;
      reY <= '0; imY <= '0;
      reZ <= '0; imZ <= '0;
      imzArmed <= 1'b0;
      DispOut <= '0;
      DispValid <= 1'b0;
      Overflow <= 1'b0;
    end else if (clear) begin
      reW <= '0; imW <= '0;
      reB <= '0; imB <= '0;
      reA <= '0; imA <= '0;
      reWB <= '0; imWB <= '0;
      reY <= '0; imY <= '0;
      reZ <= '0; imZ <= '0;
      imzArmed <= 1'b0;
      DispOut <= '0;
      DispValid <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      priority case (1'b1)
        store_W: begin
          reW <= inRe; imW <= inIm;
        end
        store_B: begin
          reB <= inRe; imB <= inIm;
        end
        store_A: begin
          reA <= inRe; imA <= inIm;
        end
        calc_ReWB: reWB <= reWBNext;
        calc_ImY:  imWB <= imWBNext;
        calc_ImZ:  imzArmed <= 1'b1;
        calc_ReZ2: begin
          imY <= sat(imYSum);
          imZ <= sat(imZSum);
          imzArmed <= 1'b0;
          if (clamps(imYSum) || clamps(imZSum)) Overflow <= 1'b1;
        end
        calc_ReZ: begin
          reZ <= sat(reZSum);
          if (clamps(reZSum)) Overflow <= 1'b1;
        end
        calc_ReY: begin
          reY <= sat(reYSum);
          if (clamps(reYSum)) Overflow <= 1'b1;
        end
        display_ReY: begin
          DispOut <= reY; DispValid <= 1'b1;
        end
        display_ImY: begin
          DispOut <= imY; DispValid <= 1'b1;
        end
        display_ReZ: begin
          DispOut <= reZ; DispValid <= 1'b1;
        end
        display_ImZ: begin
          DispOut <= imZ; DispValid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
